// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencing controller.
// Holds prefix byte values, FSM state encoding and the held-key record.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       held;
  } key_evt_t;

endpackage

// File: rtl/ps2_prefix_dec.sv
// Combinational scan-code classifier: byte + pending prefixes + held key
// in; new-make / matching-release strobes and next prefix flags out.
module ps2_prefix_dec
  import ps2_pkg::*;
(
  input  logic [7:0] data,
  input  logic       brk_pend,
  input  logic       ext_pend,
  input  key_evt_t   key,
  output logic       is_make,
  output logic       is_rel,
  output logic       nxt_brk,
  output logic       nxt_ext
);

  logic is_brk;
  logic is_ext;
  logic match;

  assign is_brk = (data == PS2_BREAK);
  assign is_ext = (data == PS2_EXT);
  assign match  = key.held
               && (data == key.code)
               && (ext_pend == key.ext);

  // Prefixes accumulate; a plain byte
  // consumes and clears both flags.
  always_comb begin
    is_make = 1'b0;
    is_rel  = 1'b0;
    nxt_brk = 1'b0;
    nxt_ext = 1'b0;
    unique case (1'b1)
      is_brk: begin
        nxt_brk = 1'b1;
        nxt_ext = ext_pend;
      end
      is_ext: begin
        nxt_brk = brk_pend;
        nxt_ext = 1'b1;
      end
      (!is_brk && !is_ext && brk_pend): begin
        is_rel = match;
      end
      (!is_brk && !is_ext && !brk_pend): begin
        is_make = !match;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key sequencer: pops FIFO bytes, tracks held key, counts makes.
// Ports: FIFO handshake in, held-key/pulse/count/overflow/display out.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 1
) (
  input  logic             clk_i,
  input  logic             clrn_i,
  input  logic             ready_i,
  input  logic [7:0]       data_i,
  input  logic             overflow_i,
  output logic             nextdata_n_o,
  output logic [7:0]       key_code_o,
  output logic             key_ext_o,
  output logic             key_held_o,
  output logic             make_pulse_o,
  output logic             break_pulse_o,
  output logic [CNT_W-1:0] press_cnt_o,
  output logic             overflow_o,
  output logic             disp_en_o
);

  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYC - 1);

  state_t           state;
  state_t           nxt_state;
  logic [7:0]       byte_r;
  logic [GW-1:0]    gap_cnt;
  logic             brk_pend;
  logic             ext_pend;
  key_evt_t         key;
  logic             mk_pulse;
  logic             bk_pulse;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             pop_n;

  logic is_make;
  logic is_rel;
  logic nxt_brk;
  logic nxt_ext;

  ps2_prefix_dec u_dec (
    .data     (byte_r),
    .brk_pend (brk_pend),
    .ext_pend (ext_pend),
    .key      (key),
    .is_make  (is_make),
    .is_rel   (is_rel),
    .nxt_brk  (nxt_brk),
    .nxt_ext  (nxt_ext)
  );

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // The GAP hold keeps a stale ready_i from
  // causing a second pop of the same byte.
  always_comb begin
    nxt_state = state;
    pop_n     = 1'b1;
    unique case (state)
      IDLE: begin
        if (ready_i) nxt_state = POP;
      end
      POP: begin
        pop_n     = 1'b0;
        nxt_state = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      byte_r  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == IDLE && ready_i)
        byte_r <= data_i;
      if (state == GAP)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      key      <= '0;
      mk_pulse <= 1'b0;
      bk_pulse <= 1'b0;
      cnt      <= '0;
    end else begin
      mk_pulse <= 1'b0;
      bk_pulse <= 1'b0;
      if (state == POP) begin
        brk_pend <= nxt_brk;
        ext_pend <= nxt_ext;
        if (is_make) begin
          key      <= '{code: byte_r,
                        ext:  ext_pend,
                        held: 1'b1};
          cnt      <= cnt + 1'b1;
          mk_pulse <= 1'b1;
        end
        if (is_rel) begin
          key.held <= 1'b0;
          bk_pulse <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      ovf <= 1'b0;
    end else if (overflow_i) begin
      ovf <= 1'b1;
    end
  end

  assign nextdata_n_o  = pop_n;
  assign key_code_o    = key.code;
  assign key_ext_o     = key.ext;
  assign key_held_o    = key.held;
  assign disp_en_o     = key.held;
  assign make_pulse_o  = mk_pulse;
  assign break_pulse_o = bk_pulse;
  assign press_cnt_o   = cnt;
  assign overflow_o    = ovf;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a FIFO model on the handshake.
// Table of per-byte expectations plus burst, overflow and reset runs.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [7:0] data;
  logic       ovf_in;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic       make_pulse;
  logic       break_pulse;
  logic [7:0] press_cnt;
  logic       ovf_out;
  logic       disp_en;

  ps2_key_ctrl #(.CNT_W(8), .GAP_CYC(1)) dut (
    .clk_i         (clk),
    .clrn_i        (rst_n),
    .ready_i       (ready),
    .data_i        (data),
    .overflow_i    (ovf_in),
    .nextdata_n_o  (nextdata_n),
    .key_code_o    (key_code),
    .key_ext_o     (key_ext),
    .key_held_o    (key_held),
    .make_pulse_o  (make_pulse),
    .break_pulse_o (break_pulse),
    .press_cnt_o   (press_cnt),
    .overflow_o    (ovf_out),
    .disp_en_o     (disp_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic [7:0] cnt;
    int         mk;
    int         bk;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int underflow = 0;
  int last_pop = -1;
  int sp_err = 0;
  int sp_on = 0;
  int mk_cnt = 0;
  int bk_cnt = 0;
  int wid_err = 0;
  logic mk_prev = 1'b0;
  logic bk_prev = 1'b0;

  // FIFO model and pulse monitor, all on the falling edge.
  initial begin
    ready = 1'b0;
    data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && !nextdata_n) begin
        if (q.size() > 0) q.delete(0);
        else underflow++;
        pops++;
        if (sp_on != 0 && last_pop >= 0
            && cyc - last_pop != 3)
          sp_err++;
        last_pop = cyc;
      end
      if (make_pulse) mk_cnt++;
      if (break_pulse) bk_cnt++;
      if (make_pulse && mk_prev) wid_err++;
      if (break_pulse && bk_prev) wid_err++;
      mk_prev = make_pulse;
      bk_prev = break_pulse;
      ready = (q.size() != 0);
      data  = (q.size() != 0) ? q[0] : 8'h00;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b,
                     input logic [7:0] code,
                     input logic ext, input logic held,
                     input logic [7:0] cnt,
                     input int mk, input int bk);
    vec_t v;
    v.b = b; v.code = code; v.ext = ext;
    v.held = held; v.cnt = cnt;
    v.mk = mk; v.bk = bk;
    tv.push_back(v);
  endtask

  task automatic wait_pop();
    int p0;
    int k;
    p0 = pops;
    k = 0;
    while (pops == p0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    chk("pop_seen", 32'(pops != p0), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int m0;
    int b0;
    int p0;
    int k;
    logic [7:0] c;

    rst_n  = 1'b0;
    ovf_in = 1'b0;
    // b     code   ext held cnt  mk bk
    add(8'h1C, 8'h1C, 0, 1, 8'd1, 1, 0);
    add(8'h1C, 8'h1C, 0, 1, 8'd1, 0, 0);
    add(8'h1C, 8'h1C, 0, 1, 8'd1, 0, 0);
    add(8'hF0, 8'h1C, 0, 1, 8'd1, 0, 0);
    add(8'h1C, 8'h1C, 0, 0, 8'd1, 0, 1);
    add(8'hE0, 8'h1C, 0, 0, 8'd1, 0, 0);
    add(8'h75, 8'h75, 1, 1, 8'd2, 1, 0);
    add(8'hE0, 8'h75, 1, 1, 8'd2, 0, 0);
    add(8'hF0, 8'h75, 1, 1, 8'd2, 0, 0);
    add(8'h75, 8'h75, 1, 0, 8'd2, 0, 1);
    add(8'hE0, 8'h75, 1, 0, 8'd2, 0, 0);
    add(8'h75, 8'h75, 1, 1, 8'd3, 1, 0);
    add(8'hF0, 8'h75, 1, 1, 8'd3, 0, 0);
    add(8'h75, 8'h75, 1, 1, 8'd3, 0, 0);
    add(8'hE0, 8'h75, 1, 1, 8'd3, 0, 0);
    add(8'hF0, 8'h75, 1, 1, 8'd3, 0, 0);
    add(8'h75, 8'h75, 1, 0, 8'd3, 0, 1);
    add(8'hF0, 8'h75, 1, 0, 8'd3, 0, 0);
    add(8'hF0, 8'h75, 1, 0, 8'd3, 0, 0);
    add(8'h1C, 8'h75, 1, 0, 8'd3, 0, 0);
    add(8'h1C, 8'h1C, 0, 1, 8'd4, 1, 0);
    add(8'hF0, 8'h1C, 0, 1, 8'd4, 0, 0);
    add(8'hE0, 8'h1C, 0, 1, 8'd4, 0, 0);
    add(8'h1C, 8'h1C, 0, 1, 8'd4, 0, 0);
    add(8'hF0, 8'h1C, 0, 1, 8'd4, 0, 0);
    add(8'h1C, 8'h1C, 0, 0, 8'd4, 0, 1);
    add(8'hE0, 8'h1C, 0, 0, 8'd4, 0, 0);
    add(8'h1C, 8'h1C, 1, 1, 8'd5, 1, 0);
    add(8'h1C, 8'h1C, 0, 1, 8'd6, 1, 0);
    add(8'h29, 8'h29, 0, 1, 8'd7, 1, 0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_code", 32'(key_code), 32'h00);
    chk("rst_ext", 32'(key_ext), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    chk("rst_disp", 32'(disp_en), 32'd0);
    chk("rst_pulses",
        32'({make_pulse, break_pulse}), 32'd0);

    foreach (tv[i]) begin
      m0 = mk_cnt;
      b0 = bk_cnt;
      q.push_back(tv[i].b);
      wait_pop();
      repeat (3) @(posedge clk);
      #2;
      chk($sformatf("v%0d_code", i),
          32'(key_code), 32'(tv[i].code));
      chk($sformatf("v%0d_ext", i),
          32'(key_ext), 32'(tv[i].ext));
      chk($sformatf("v%0d_held", i),
          32'(key_held), 32'(tv[i].held));
      chk($sformatf("v%0d_disp", i),
          32'(disp_en), 32'(tv[i].held));
      chk($sformatf("v%0d_cnt", i),
          32'(press_cnt), 32'(tv[i].cnt));
      chk($sformatf("v%0d_make", i),
          32'(mk_cnt - m0), 32'(tv[i].mk));
      chk($sformatf("v%0d_break", i),
          32'(bk_cnt - b0), 32'(tv[i].bk));
    end

    @(posedge clk); #2 ovf_in = 1'b1;
    @(posedge clk); #2 ovf_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("ovf_sticky", 32'(ovf_out), 32'd1);

    q.push_back(8'hF0);
    wait_pop();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_held", 32'(key_held), 32'd0);
    chk("mid_rst_code", 32'(key_code), 32'h00);
    chk("mid_rst_cnt", 32'(press_cnt), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_out), 32'd0);
    chk("mid_rst_nd", 32'(nextdata_n), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    m0 = mk_cnt;
    q.push_back(8'h1C);
    wait_pop();
    repeat (3) @(posedge clk);
    #2;
    chk("post_rst_held", 32'(key_held), 32'd1);
    chk("post_rst_code", 32'(key_code), 32'h1C);
    chk("post_rst_cnt", 32'(press_cnt), 32'd1);
    chk("post_rst_make", 32'(mk_cnt - m0), 32'd1);

    do_reset();
    m0 = mk_cnt;
    b0 = bk_cnt;
    p0 = pops;
    @(negedge clk);
    sp_on = 1;
    last_pop = -1;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i % 128);
      q.push_back(c);
      q.push_back(8'hF0);
      q.push_back(c);
    end
    k = 0;
    while (pops - p0 < 768 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #2;
    sp_on = 0;
    chk("burst_pops", 32'(pops - p0), 32'd768);
    chk("burst_spacing", 32'(sp_err), 32'd0);
    chk("burst_makes", 32'(mk_cnt - m0), 32'd256);
    chk("burst_breaks", 32'(bk_cnt - b0), 32'd256);
    chk("wrap_cnt", 32'(press_cnt), 32'h00);
    chk("burst_held", 32'(key_held), 32'd0);
    chk("burst_code", 32'(key_code), 32'h7F);
    chk("fifo_underflow", 32'(underflow), 32'd0);
    chk("pulse_width", 32'(wid_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
